// File: rtl/imm_pkg.sv
// Shared opcode constants and immediate-format encoding for the immediate generator.
// Optional illegal-instruction flag is enabled by IMM_ILLEGAL_DETECT_EN.
package imm_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned FMT_W   = 3;

  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'h13;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'h03;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'h67;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'h73;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'h23;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'h63;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'h37;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'h17;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'h6F;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'h33;

  typedef enum logic [FMT_W-1:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_R    = 3'd6
  } fmt_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Fetch-side and execute-side handshake bundle of imm_gen_pipe.
// illegal_o exists only when IMM_ILLEGAL_DETECT_EN is defined.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN = 32
) ();
  import imm_pkg::*;

  logic                 valid_i;
  logic                 ready_o;
  logic [INSTR_W-1:0]   instr_i;
  logic [XLEN-1:0]      pc_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [XLEN-1:0]      imm_o;
  logic [XLEN-1:0]      target_o;
  logic [FMT_W-1:0]     fmt_o;
`ifdef IMM_ILLEGAL_DETECT_EN
  logic                 illegal_o;
`endif

  modport slave (
    input  valid_i, instr_i, pc_i, ready_i,
`ifdef IMM_ILLEGAL_DETECT_EN
    output illegal_o,
`endif
    output ready_o, valid_o, imm_o, target_o, fmt_o
  );

  modport master (
    output valid_i, instr_i, pc_i, ready_i,
`ifdef IMM_ILLEGAL_DETECT_EN
    input  illegal_o,
`endif
    input  ready_o, valid_o, imm_o, target_o, fmt_o
  );

endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RV32I immediate decode plus PC-relative target for imm_gen_pipe.
// IMM_ILLEGAL_DETECT_EN adds the illegal-opcode flag.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [XLEN-1:0]    pc_i,
`ifdef IMM_ILLEGAL_DETECT_EN
  output logic               illegal_o,
`endif
  output logic [XLEN-1:0]    imm_o,
  output logic [XLEN-1:0]    target_o,
  output fmt_e               fmt_o
);

  logic [INSTR_W-1:0] raw_c;
  logic               pc_rel_c;

  // Assemble a 32-bit sign-extended immediate, then widen it to XLEN.
  always_comb begin
    raw_c    = '0;
    fmt_o    = FMT_NONE;
    pc_rel_c = 1'b0;
    case (instr_i[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        fmt_o = FMT_I;
        raw_c = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OPC_STORE: begin
        fmt_o = FMT_S;
        raw_c = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OPC_BRANCH: begin
        fmt_o    = FMT_B;
        pc_rel_c = 1'b1;
        raw_c    = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                    instr_i[30:25], instr_i[11:8], 1'b0};
      end
      OPC_LUI: begin
        fmt_o = FMT_U;
        raw_c = {instr_i[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        fmt_o    = FMT_U;
        pc_rel_c = 1'b1;
        raw_c    = {instr_i[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt_o    = FMT_J;
        pc_rel_c = 1'b1;
        raw_c    = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                    instr_i[20], instr_i[30:21], 1'b0};
      end
      OPC_OP: begin
        fmt_o = FMT_R;
      end
      default: ;
    endcase

    imm_o    = XLEN'($signed(raw_c));
    target_o = pc_i + (pc_rel_c ? imm_o : XLEN'(4));
  end

`ifdef IMM_ILLEGAL_DETECT_EN
  // Every listed opcode ends in 2'b11 and yields a non-NONE format.
  assign illegal_o = (fmt_o == FMT_NONE) || (instr_i[1:0] != 2'b11);
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: imm_decode followed by a two-entry skid buffer.
// IMM_ILLEGAL_DETECT_EN carries an illegal-opcode flag alongside the bundle.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  imm_gen_pipe_if.slave   bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    fmt_e            fmt;
`ifdef IMM_ILLEGAL_DETECT_EN
    logic            illegal;
`endif
  } bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e          state_q;
  logic            valid_q;
  logic            ready_q;
  bundle_t         out_q;
  bundle_t         skid_q;
  bundle_t         dec_d;
  logic            accept_c;

  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_target;
  fmt_e            dec_fmt;
`ifdef IMM_ILLEGAL_DETECT_EN
  logic            dec_illegal;
`endif

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i   (bus.instr_i),
    .pc_i      (bus.pc_i),
`ifdef IMM_ILLEGAL_DETECT_EN
    .illegal_o (dec_illegal),
`endif
    .imm_o     (dec_imm),
    .target_o  (dec_target),
    .fmt_o     (dec_fmt)
  );

  always_comb begin
    dec_d        = '0;
    dec_d.imm    = dec_imm;
    dec_d.target = dec_target;
    dec_d.fmt    = dec_fmt;
`ifdef IMM_ILLEGAL_DETECT_EN
    dec_d.illegal = dec_illegal;
`endif
  end

  assign accept_c = bus.valid_i & ready_q;

  // Skid FSM: ready depends only on registered state, never on ready_i.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            out_q   <= dec_d;
            state_q <= ST_ONE;
            valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (bus.ready_i) begin
            if (accept_c) begin
              out_q <= dec_d;
            end else begin
              state_q <= ST_EMPTY;
              valid_q <= 1'b0;
            end
          end else if (accept_c) begin
            skid_q  <= dec_d;
            state_q <= ST_FULL;
            ready_q <= 1'b0;
          end
        end
        ST_FULL: begin
          if (bus.ready_i) begin
            out_q   <= skid_q;
            state_q <= ST_ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.valid_o   = valid_q;
  assign bus.ready_o   = ready_q;
  assign bus.imm_o     = out_q.imm;
  assign bus.target_o  = out_q.target;
  assign bus.fmt_o     = out_q.fmt;
`ifdef IMM_ILLEGAL_DETECT_EN
  assign bus.illegal_o = out_q.illegal;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe at XLEN=32 and XLEN=64.
// Illegal-flag vectors are included when IMM_ILLEGAL_DETECT_EN is defined.
module tb_imm_gen_pipe;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  imm_gen_pipe_if #(.XLEN(32)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64)) bus64 ();

  imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .reset(reset), .bus(bus64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic v, input logic [31:0] imm,
                       input logic [31:0] tgt, input logic [2:0] fmt);
    check({tag, ".valid"},  64'(bus32.valid_o),  64'(v));
    check({tag, ".imm"},    64'(bus32.imm_o),    64'(imm));
    check({tag, ".target"}, 64'(bus32.target_o), 64'(tgt));
    check({tag, ".fmt"},    64'(bus32.fmt_o),    64'(fmt));
  endtask

  task automatic send32(input logic [31:0] instr, input logic [31:0] pc);
    bus32.valid_i = 1'b1;
    bus32.instr_i = instr;
    bus32.pc_i    = pc;
    tick();
  endtask

  task automatic send64(input logic [31:0] instr, input logic [63:0] pc);
    bus64.valid_i = 1'b1;
    bus64.instr_i = instr;
    bus64.pc_i    = pc;
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    bus32.valid_i = 1'b0; bus32.instr_i = '0; bus32.pc_i = '0; bus32.ready_i = 1'b1;
    bus64.valid_i = 1'b0; bus64.instr_i = '0; bus64.pc_i = '0; bus64.ready_i = 1'b1;
    repeat (2) tick();
    reset = 1'b1;

    check("rst.ready", 64'(bus32.ready_o), 64'd1);
    chk32("rst", 1'b0, 32'h0, 32'h0, 3'd0);

    // Back-to-back decode vectors with ready_i=1
    send32(32'hFFF00093, 32'h100); chk32("addi", 1'b1, 32'hFFFFFFFF, 32'h104, 3'd1);
`ifdef IMM_ILLEGAL_DETECT_EN
    check("addi.ill", 64'(bus32.illegal_o), 64'd0);
`endif
    send32(32'hFE000EE3, 32'h100); chk32("beq", 1'b1, 32'hFFFFFFFC, 32'hFC, 3'd3);
`ifdef IMM_ILLEGAL_DETECT_EN
    check("beq.ill", 64'(bus32.illegal_o), 64'd0);
`endif
    send32(32'h8000006F, 32'h100); chk32("jal", 1'b1, 32'hFFF00000, 32'hFFF00100, 3'd5);
`ifdef IMM_ILLEGAL_DETECT_EN
    check("jal.ill", 64'(bus32.illegal_o), 64'd0);
`endif
    send32(32'h00001017, 32'hFFFFF000); chk32("auipc", 1'b1, 32'h00001000, 32'h0, 3'd4);
`ifdef IMM_ILLEGAL_DETECT_EN
    check("auipc.ill", 64'(bus32.illegal_o), 64'd0);
`endif
    send32(32'hFE112E23, 32'h100); chk32("sw", 1'b1, 32'hFFFFFFFC, 32'h104, 3'd2);
    send32(32'h002081B3, 32'h100); chk32("add", 1'b1, 32'h0, 32'h104, 3'd6);
    send32(32'h800000B7, 32'h100); chk32("lui", 1'b1, 32'h80000000, 32'h104, 3'd4);
    send32(32'h0000007F, 32'h100); chk32("unk", 1'b1, 32'h0, 32'h104, 3'd0);
`ifdef IMM_ILLEGAL_DETECT_EN
    check("unk.ill", 64'(bus32.illegal_o), 64'd1);
    send32(32'h00000090, 32'h200); chk32("lo2", 1'b1, 32'h0, 32'h204, 3'd0);
    check("lo2.ill", 64'(bus32.illegal_o), 64'd1);
`endif
    bus32.valid_i = 1'b0;
    tick();
    check("drain.valid", 64'(bus32.valid_o), 64'd0);

    // Backpressure: three back-to-back instructions while ready_i=0
    bus32.ready_i = 1'b0;
    send32(32'h00100093, 32'h0);
    chk32("bp1", 1'b1, 32'd1, 32'h4, 3'd1);
    check("bp1.ready", 64'(bus32.ready_o), 64'd1);
    send32(32'h00200093, 32'h0);
    check("bp2.ready", 64'(bus32.ready_o), 64'd0);
    check("bp2.hold", 64'(bus32.imm_o), 64'd1);
    send32(32'h00300093, 32'h0);
    check("bp3.ready", 64'(bus32.ready_o), 64'd0);
    chk32("bp3.hold", 1'b1, 32'd1, 32'h4, 3'd1);
    bus32.ready_i = 1'b1;
    tick();
    chk32("bp.out2", 1'b1, 32'd2, 32'h4, 3'd1);
    check("bp.out2.ready", 64'(bus32.ready_o), 64'd1);
    tick();
    chk32("bp.out3", 1'b1, 32'd3, 32'h4, 3'd1);
    bus32.valid_i = 1'b0;
    tick();
    check("bp.empty", 64'(bus32.valid_o), 64'd0);

    // Reset while FULL discards both entries
    bus32.ready_i = 1'b0;
    send32(32'h00100093, 32'h0);
    send32(32'h00200093, 32'h0);
    check("rf.full", 64'(bus32.ready_o), 64'd0);
    bus32.instr_i = 32'h00300093;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus32.valid_i = 1'b0;
    bus32.ready_i = 1'b1;
    check("rf.ready", 64'(bus32.ready_o), 64'd1);
    chk32("rf", 1'b0, 32'h0, 32'h0, 3'd0);
    send32(32'h00400093, 32'h10);
    chk32("rf.post", 1'b1, 32'd4, 32'h14, 3'd1);
    bus32.valid_i = 1'b0;
    tick();
    check("rf.alone", 64'(bus32.valid_o), 64'd0);
    tick();
    check("rf.alone2", 64'(bus32.valid_o), 64'd0);

    // XLEN=64 sign extension and wrap
    send64(32'h800000B7, 64'h0);
    check("x64.lui.imm", bus64.imm_o, 64'hFFFFFFFF80000000);
    check("x64.lui.tgt", bus64.target_o, 64'h4);
    check("x64.lui.fmt", 64'(bus64.fmt_o), 64'd4);
    send64(32'hFE000EE3, 64'h100);
    check("x64.beq.imm", bus64.imm_o, 64'hFFFFFFFFFFFFFFFC);
    check("x64.beq.tgt", bus64.target_o, 64'hFC);
    send64(32'h00001017, 64'hFFFFFFFFFFFFF000);
    check("x64.auipc.imm", bus64.imm_o, 64'h1000);
    check("x64.auipc.tgt", bus64.target_o, 64'h0);
`ifdef IMM_ILLEGAL_DETECT_EN
    check("x64.auipc.ill", 64'(bus64.illegal_o), 64'd0);
`endif
    bus64.valid_i = 1'b0;
    tick();
    check("x64.empty", 64'(bus64.valid_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
